fp_cvt128_to32_pipe: RTL
========================

// Module: fp_cvt128_to32_pipe
// PURPOSE
//  Narrowing IEEE-754 convert: quad (FP128) to single (FP32), with rounding and exception flags.
//  3-stage pipeline with valid/ready handshake on both sides; 1 result/cycle throughput.
//  Counterpart of the single-to-quad widening convert; sits in the FPU convert path.
// PARAMETERS
//  TAG_W   4   width of opaque tag carried alongside each operand, returned unchanged
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand valid
//  in_ready   out  1      block can accept operand this cycle
//  i          in   128    FP128 operand {sign, exp[14:0], sig[111:0]}
//  rm         in   3      round mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
//  tag_i      in   TAG_W  opaque tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  o          out  32     FP32 result
//  tag_o      out  TAG_W  tag of result
//  flags      out  5      {invalid, overflow, underflow, inexact, 1'b0 (reserved, divide-by-zero slot)}
// BEHAVIOUR
//  Reset: all stage valid bits 0; out_valid=0, o=0, tag_o=0, flags=0. Reset mid-stream drops all in-flight ops.
//  Handshake: transfer when valid&ready. Stage k loads when empty or advancing; in_ready = ~v1 | adv1.
//   Latency 3 cycles (accept at edge N, out_valid at N+3) with out_ready high. Results in order, no loss/dup.
//   While out_valid & ~out_ready: o, tag_o, flags held stable.
//  S1 unpack: classify zero/inf/qNaN/sNaN/quad-subnormal; e = exp - 16383 + 127 as 17-bit signed.
//  S2 align: m = {1, sig[111:89]}, G = sig[88], R = sig[87], S = |sig[86:0].
//   e >= 255: overflow. e <= 0: shift {m,G,R} right by 1-e (capped at 26), shifted-out bits OR into S; exp field 0.
//  S3 round (RNE tie->even, RMM tie->away, RUP/RDN sign-directed, RTZ truncate):
//   mantissa carry: normal -> exp+1; subnormal carry into bit 23 -> exp=1. exp reaching 255 -> overflow.
//  Overflow result: RNE/RMM +-inf; RTZ +-0x7F7FFFFF; RDN +max / -inf; RUP +inf / -max. Sets overflow+inexact.
//  Quad subnormal input: result +-0, except RUP(+)/RDN(-) -> +-0x00000001; underflow+inexact.
//  Underflow flag: tiny (pre-round exp<=0) AND inexact. inexact: any of G|R|S nonzero, or overflow.
//  Zero -> +-0 exact. Inf -> +-0x7F800000 exact.
//  NaN: o = {sign, 8'hFF, 1, sig[110:89]} (quiet). invalid set only for sNaN (sig[111]==0, sig!=0).
// STRUCTURE
//  Shared package fpPkg: round-mode enum (RNE..RMM), flag struct, FP32/FP128 types from existing fp32/fp128 pkgs.
//  One sub-module: fp_round32 -- combinational rounder (sign, mant, G/R/S, exp, rm -> FP32, ovf, inx).
//  Top: three pipeline registers + per-stage valid + ready chain.
// TESTING
//  1: i=0x3FFF0000_00000000_00000000_00000000, RNE -> o=0x3F800000 at accept+3, flags=0.
//  2: i=0x7FFEFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF: RNE -> 0x7F800000 ovf+inx; RTZ -> 0x7F7FFFFF ovf+inx.
//  3: i=0x3FFF0000_01000000_00000000_00000000 (1+2^-24 tie): RNE -> 0x3F800000 inx; RUP -> 0x3F800001 inx.
//  4: 2^-149 (exp 0x3F6A, sig 0) -> 0x00000001 no flags; 2^-150 (exp 0x3F69) RNE -> 0x00000000 unf+inx.
//  5: sNaN i=0x7FFF4000_00000000_00000000_00000000 -> 0x7FE00000 invalid; qNaN 0x7FFF8000_0... -> 0x7FC00000 no flags.
//  6: stream 6 ops back-to-back, out_ready low 3 cycles mid-stream -> in_ready drops once 3 stages full, results/tags
//     in order, held stable while stalled; assert rst_n low mid-stream -> out_valid=0 immediately, nothing resurfaces.

Source files
------------

// File: rtl/fp_cvt128_to32_pipe_pkg.sv
// Shared types for the FP128 -> FP32 narrowing convert: round modes, flags, stage payloads.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package fp_cvt128_to32_pipe_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
    logic div_zero;   // never set by a convert, slot kept for flag-vector alignment
  } flags_t;

  typedef logic [31:0]  fp32_t;
  typedef logic [127:0] fp128_t;

  // quad bias minus single bias: 16383 - 127
  localparam logic [16:0] EXP_REBIAS = 17'd16256;

  // Stage-1 payload: classified operand, rebiased exponent, significand cut to 23+G+R+S
  typedef struct packed {
    logic        sign;
    logic        zero;
    logic        sub;
    logic        inf;
    logic        nan;
    logic        snan;
    logic [16:0] e;      // two's complement single-precision exponent
    logic [22:0] frac;
    logic        g;
    logic        r;
    logic        s;
    rm_e         rm;
  } unpk_t;

  // Stage-2 payload: operand aligned for single precision, ready to round
  typedef struct packed {
    logic        sign;
    logic        zero;
    logic        sub;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        tiny;   // pre-round exponent <= 0
    logic        ovf;    // pre-round exponent >= 255
    logic [7:0]  exp;
    logic [23:0] mant;   // with hidden bit
    logic        g;
    logic        r;
    logic        s;
    rm_e         rm;
  } algn_t;

  // Reserved round-mode encodings fall back to round-to-nearest-even
  function automatic rm_e rm_decode(input logic [2:0] raw);
    rm_e m;
    case (raw)
      3'd1:    m = RM_RTZ;
      3'd2:    m = RM_RDN;
      3'd3:    m = RM_RUP;
      3'd4:    m = RM_RMM;
      default: m = RM_RNE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fp_cvt128_to32_pipe_round32.sv
// Combinational FP32 rounder: applies round mode to mant+G/R/S, handles carries and overflow saturation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage holds the inputs stable.
module fp_cvt128_to32_pipe_round32
  import fp_cvt128_to32_pipe_pkg::*;
(
  input  logic        sign,
  input  logic [23:0] mant,
  input  logic        g,
  input  logic        r,
  input  logic        s,
  input  logic [7:0]  exp,
  input  logic        ovf_in,
  input  rm_e         rm,
  output fp32_t       res,
  output logic        ovf,
  output logic        inx
);

  logic        any_lost;
  logic        up;
  logic        to_inf;
  logic [24:0] sum;
  logic [8:0]  exp_r;
  logic [22:0] frac_r;

  // Increment decision, mantissa carry into the exponent, and overflow result selection
  always_comb begin
    any_lost = g | r | s;
    case (rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sign & any_lost;
      RM_RUP:  up = ~sign & any_lost;
      RM_RMM:  up = g;
      default: up = g & (r | s | mant[0]);
    endcase
    sum    = {1'b0, mant} + {24'd0, up};
    exp_r  = {1'b0, exp};
    frac_r = sum[22:0];
    if (sum[24]) begin
      // 1.111..1 rounded up: mantissa becomes 1.0, exponent bumps
      exp_r  = exp_r + 9'd1;
      frac_r = sum[23:1];
    end else if (exp == 8'd0 && sum[23]) begin
      // largest subnormal rounded up into the smallest normal
      exp_r = 9'd1;
    end
    ovf    = ovf_in | (exp_r >= 9'd255);
    inx    = any_lost | ovf;
    // directed modes saturate to max-finite when rounding toward zero magnitude
    to_inf = ~((rm == RM_RTZ) | ((rm == RM_RDN) & ~sign) | ((rm == RM_RUP) & sign));
    if (ovf) res = to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
    else     res = {sign, exp_r[7:0], frac_r};
  end

endmodule

// File: rtl/fp_cvt128_to32_pipe.sv
// FP128 -> FP32 narrowing convert with rounding and IEEE exception flags, tag carried alongside.
// Latency: 3 cycles (unpack, align, round), one result per cycle.
// Backpressure: valid/ready; a stage loads when empty or advancing, outputs held while out_ready is low.
module fp_cvt128_to32_pipe
  import fp_cvt128_to32_pipe_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     i,
  input  logic [2:0]       rm,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      o,
  output logic [TAG_W-1:0] tag_o,
  output logic [4:0]       flags
);

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             rdy1, rdy2, rdy3;
  unpk_t            s1_q, s1_d, s1_n;
  algn_t            s2_q, s2_d, s2_n;
  fp32_t            o_q, o_d, o_n;
  flags_t           flags_q, flags_d, flags_n;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;

  logic [14:0]        in_exp;
  logic [111:0]       in_sig;
  logic signed [16:0] e_s;
  logic [4:0]         sh;
  logic [25:0]        pre, post, lost_mask;
  fp32_t              rnd_res;
  logic               rnd_ovf, rnd_inx;

  assign in_exp = i[126:112];
  assign in_sig = i[111:0];

  // Stage 1: classify the quad operand, rebias its exponent, fold low significand into sticky
  always_comb begin
    s1_n      = '0;
    s1_n.sign = i[127];
    s1_n.zero = (in_exp == 15'd0) && (in_sig == 112'd0);
    s1_n.sub  = (in_exp == 15'd0) && (in_sig != 112'd0);
    s1_n.inf  = (&in_exp) && (in_sig == 112'd0);
    s1_n.nan  = (&in_exp) && (in_sig != 112'd0);
    s1_n.snan = s1_n.nan && !in_sig[111];
    s1_n.e    = {2'b00, in_exp} - EXP_REBIAS;
    s1_n.frac = in_sig[111:89];
    s1_n.g    = in_sig[88];
    s1_n.r    = in_sig[87];
    s1_n.s    = |in_sig[86:0];
    s1_n.rm   = rm_decode(rm);
  end

  // Stage 2: flag out-of-range exponents, denormalise tiny values with sticky collection
  always_comb begin
    e_s       = signed'(s1_q.e);
    s2_n      = '0;
    s2_n.sign = s1_q.sign;
    s2_n.zero = s1_q.zero;
    s2_n.sub  = s1_q.sub;
    s2_n.inf  = s1_q.inf;
    s2_n.nan  = s1_q.nan;
    s2_n.snan = s1_q.snan;
    s2_n.rm   = s1_q.rm;
    s2_n.ovf  = (e_s >= 17'sd255);
    s2_n.tiny = (e_s <= 17'sd0);
    pre       = {1'b1, s1_q.frac, s1_q.g, s1_q.r};
    sh        = 5'd0;
    if (e_s <= -17'sd25)  sh = 5'd26;   // everything lands in sticky
    else if (s2_n.tiny)   sh = 5'(17'd1 - s1_q.e);
    lost_mask = (26'd1 << sh) - 26'd1;
    post      = pre >> sh;
    s2_n.exp  = s2_n.tiny ? 8'd0 : s1_q.e[7:0];
    s2_n.mant = post[25:2];
    s2_n.g    = post[1];
    s2_n.r    = post[0];
    s2_n.s    = s1_q.s | (|(pre & lost_mask));
  end

  fp_cvt128_to32_pipe_round32 u_round (
    .sign   (s2_q.sign),
    .mant   (s2_q.mant),
    .g      (s2_q.g),
    .r      (s2_q.r),
    .s      (s2_q.s),
    .exp    (s2_q.exp),
    .ovf_in (s2_q.ovf),
    .rm     (s2_q.rm),
    .res    (rnd_res),
    .ovf    (rnd_ovf),
    .inx    (rnd_inx)
  );

  // Stage 3: special operands bypass the rounder; finite results take its value and flags
  always_comb begin
    o_n     = rnd_res;
    flags_n = '0;
    if (s2_q.nan) begin
      o_n             = {s2_q.sign, 8'hFF, 1'b1, s2_q.mant[21:0]};
      flags_n.invalid = s2_q.snan;
    end else if (s2_q.inf) begin
      o_n = {s2_q.sign, 8'hFF, 23'd0};
    end else if (s2_q.zero) begin
      o_n = {s2_q.sign, 31'd0};
    end else if (s2_q.sub) begin
      // quad subnormals are far below FP32 range: only directed rounding away from zero yields 1 ulp
      o_n = {s2_q.sign, 30'd0,
             ((s2_q.rm == RM_RUP) & ~s2_q.sign) | ((s2_q.rm == RM_RDN) & s2_q.sign)};
      flags_n.underflow = 1'b1;
      flags_n.inexact   = 1'b1;
    end else begin
      flags_n.overflow  = rnd_ovf;
      flags_n.inexact   = rnd_inx;
      flags_n.underflow = s2_q.tiny & rnd_inx;
    end
  end

  // Ready chain and next-state selection: a stage loads when empty or its contents move on
  always_comb begin
    rdy3    = ~v3_q | out_ready;
    rdy2    = ~v2_q | rdy3;
    rdy1    = ~v1_q | rdy2;
    v1_d    = rdy1 ? in_valid : v1_q;
    v2_d    = rdy2 ? v1_q : v2_q;
    v3_d    = rdy3 ? v2_q : v3_q;
    s1_d    = s1_q;
    tag1_d  = tag1_q;
    s2_d    = s2_q;
    tag2_d  = tag2_q;
    o_d     = o_q;
    flags_d = flags_q;
    tag3_d  = tag3_q;
    if (rdy1 && in_valid) begin
      s1_d   = s1_n;
      tag1_d = tag_i;
    end
    if (rdy2 && v1_q) begin
      s2_d   = s2_n;
      tag2_d = tag1_q;
    end
    if (rdy3 && v2_q) begin
      o_d     = o_n;
      flags_d = flags_n;
      tag3_d  = tag2_q;
    end
  end

  // Pipeline state; reset drops every in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      o_q     <= '0;
      flags_q <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      tag3_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      o_q     <= o_d;
      flags_q <= flags_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      tag3_q  <= tag3_d;
    end
  end

  assign in_ready  = rdy1;
  assign out_valid = v3_q;
  assign o         = o_q;
  assign tag_o     = tag3_q;
  assign flags     = flags_q;

endmodule
